// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: one outstanding word fetch, DEPTH-entry {pc, inst}
// prefetch queue toward decode, redirect with flush and in-flight response squash.
module inst_fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    output logic            req_valid,
    output logic [XLEN-1:0] req_addr,
    input  logic            req_ready,
    input  logic            resp_valid,
    input  logic [XLEN-1:0] resp_inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   fetch_pc, pending_pc;
    logic [XLEN-1:0]   q_pc   [DEPTH];
    logic [XLEN-1:0]   q_inst [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic              redir, req_fire, push, pop;
    logic [XLEN-1:0]   redirect_base;

    assign redir         = rdy_in && redirect_valid;
    assign redirect_base = redirect_pc & ~XLEN'(3);
    assign req_fire      = req_valid && req_ready;
    assign req_addr      = fetch_pc;
    assign inst_out      = q_inst[head];
    assign inst_pc       = q_pc[head];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    // A returning response always closes the outstanding request, whether kept or squashed
    always_comb begin
        state_nxt = state;
        if (rdy_in) begin
            case (state)
                IDLE:    if (req_fire) state_nxt = WAIT;
                WAIT:    if (resp_valid) state_nxt = IDLE;
                         else if (redir) state_nxt = DROP;
                DROP:    if (resp_valid) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        req_valid  = rdy_in && !rst_in && (state == IDLE) && !redirect_valid
                     && (count < CNT_W'(DEPTH));
        inst_valid = rdy_in && (count != '0);
        push       = rdy_in && !redir && (state == WAIT) && resp_valid;
        pop        = inst_valid && inst_ready && !redir;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            fetch_pc   <= RESET_PC;
            pending_pc <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
        end else if (redir) begin
            fetch_pc <= redirect_base;
            head     <= tail;
            count    <= '0;
        end else if (rdy_in) begin
            if (req_fire) begin
                pending_pc <= fetch_pc;
                fetch_pc   <= fetch_pc + XLEN'(4);
            end
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            q_pc[tail]   <= pending_pc;
            q_inst[tail] <= resp_inst;
        end
    end
endmodule
